// File: rtl/turf_event_fragmenter_if.sv
// Stream handshake bundle shared by the fragmenter's descriptor, payload and UDP ports.
// Header-only streams leave tkeep/tlast unused on the receiving side.
interface turf_event_fragmenter_if #(
  parameter int unsigned DATA_W = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/turf_event_fragmenter.sv
// Splits each event into UDP-sized fragments, one UDP header descriptor per fragment.
// Define TURF_FRAG_HEADER_EN to prefix every fragment with a 64-bit fragment header qword.
module turf_event_fragmenter #(
  parameter int unsigned MAX_FRAG_QWORDS = 1024
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  turf_event_fragmenter_if.slave   s_evhdr,
  turf_event_fragmenter_if.slave   s_evdata,
  turf_event_fragmenter_if.master  m_udphdr,
  turf_event_fragmenter_if.master  m_udpdata,
  input  logic [9:0]               nfragment_count_i,
  input  logic [31:0]              event_ip_i,
  input  logic [15:0]              event_port_i,
  input  logic                     event_open_i,
  output logic                     frag_err_o
);

  typedef enum logic [2:0] {IDLE, LATCH, WRITE_HEADER, WRITE_PAYLOAD, DUMP} state_t;

`ifdef TURF_FRAG_HEADER_EN
  localparam logic [15:0] HDR_QW = 16'd1;
`else
  localparam logic [15:0] HDR_QW = 16'd0;
`endif
  localparam logic [15:0] MAX_FRAG = 16'(MAX_FRAG_QWORDS);

  state_t      state_q;
  logic [15:0] len_q, remaining_q, frag_q, beat_q, cnt_q, fsize_q;
  logic [31:0] ip_q;
  logic [15:0] port_q;
  logic        evhdr_rdy_q, udphdr_vld_q, err_q;
`ifdef TURF_FRAG_HEADER_EN
  logic [15:0] evnum_q, frag_idx_q;
  logic        hdr_phase_q;
`endif

  logic        hdr_phase, payload_st, data_beat, final_beat, frag_end;
  logic [15:0] fsize_in, rem_after;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  assign fsize_in   = min16(16'(nfragment_count_i) + 16'd1, MAX_FRAG);
  assign payload_st = (state_q == WRITE_PAYLOAD);
  assign data_beat  = s_evdata.tvalid && s_evdata.tready;
  assign final_beat = (cnt_q == len_q - 16'd1);
  assign frag_end   = (beat_q == frag_q - 16'd1);
  assign rem_after  = remaining_q - frag_q;

`ifdef TURF_FRAG_HEADER_EN
  assign hdr_phase       = hdr_phase_q;
  assign m_udpdata.tdata = hdr_phase_q
                         ? {evnum_q, frag_idx_q, 15'd0, (frag_q == remaining_q), frag_q}
                         : s_evdata.tdata;
`else
  assign hdr_phase       = 1'b0;
  assign m_udpdata.tdata = s_evdata.tdata;
`endif

  assign s_evhdr.tready   = evhdr_rdy_q;
  assign m_udphdr.tvalid  = udphdr_vld_q;
  assign m_udphdr.tdata   = {ip_q, port_q, (frag_q + HDR_QW) << 3};
  assign m_udphdr.tkeep   = '1;
  assign m_udphdr.tlast   = 1'b1;

  // Payload beats are a combinational pass-through; only the header qword is sourced locally.
  assign m_udpdata.tvalid = payload_st && (hdr_phase || s_evdata.tvalid);
  assign m_udpdata.tkeep  = '1;
  assign m_udpdata.tlast  = payload_st && !hdr_phase && frag_end;
  assign s_evdata.tready  = (state_q == DUMP) || (payload_st && !hdr_phase && m_udpdata.tready);
  assign frag_err_o       = err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      len_q        <= '0;
      remaining_q  <= '0;
      frag_q       <= '0;
      beat_q       <= '0;
      cnt_q        <= '0;
      fsize_q      <= '0;
      ip_q         <= '0;
      port_q       <= '0;
      evhdr_rdy_q  <= 1'b0;
      udphdr_vld_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef TURF_FRAG_HEADER_EN
      evnum_q      <= '0;
      frag_idx_q   <= '0;
      hdr_phase_q  <= 1'b0;
`endif
    end else begin
      // Framing follows the descriptor length; tlast is only audited.
      if (data_beat && (s_evdata.tlast != final_beat)) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (evhdr_rdy_q && s_evhdr.tvalid) begin
            len_q       <= s_evhdr.tdata[15:0];
`ifdef TURF_FRAG_HEADER_EN
            evnum_q     <= s_evhdr.tdata[31:16];
`endif
            evhdr_rdy_q <= 1'b0;
            state_q     <= LATCH;
          end else begin
            evhdr_rdy_q <= 1'b1;
          end
        end
        LATCH: begin
          ip_q    <= event_ip_i;
          port_q  <= event_port_i;
          fsize_q <= fsize_in;
          cnt_q   <= '0;
          beat_q  <= '0;
          if (len_q == 16'd0) begin
            evhdr_rdy_q <= 1'b1;
            state_q     <= IDLE;
          end else if (!event_open_i) begin
            state_q <= DUMP;
          end else begin
            remaining_q  <= len_q;
            frag_q       <= min16(len_q, fsize_in);
`ifdef TURF_FRAG_HEADER_EN
            frag_idx_q   <= '0;
`endif
            udphdr_vld_q <= 1'b1;
            state_q      <= WRITE_HEADER;
          end
        end
        WRITE_HEADER: begin
          if (m_udphdr.tready) begin
            udphdr_vld_q <= 1'b0;
`ifdef TURF_FRAG_HEADER_EN
            hdr_phase_q  <= 1'b1;
`endif
            state_q      <= WRITE_PAYLOAD;
          end
        end
        WRITE_PAYLOAD: begin
`ifdef TURF_FRAG_HEADER_EN
          if (hdr_phase_q) begin
            if (m_udpdata.tready) hdr_phase_q <= 1'b0;
          end else
`endif
          if (data_beat) begin
            cnt_q  <= cnt_q + 16'd1;
            beat_q <= beat_q + 16'd1;
            if (frag_end) begin
              remaining_q <= rem_after;
              beat_q      <= '0;
`ifdef TURF_FRAG_HEADER_EN
              frag_idx_q  <= frag_idx_q + 16'd1;
`endif
              if (rem_after != 16'd0) begin
                frag_q       <= min16(rem_after, fsize_q);
                udphdr_vld_q <= 1'b1;
                state_q      <= WRITE_HEADER;
              end else begin
                evhdr_rdy_q <= 1'b1;
                state_q     <= IDLE;
              end
            end
          end
        end
        DUMP: begin
          if (data_beat) begin
            cnt_q <= cnt_q + 16'd1;
            if (final_beat) begin
              evhdr_rdy_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turf_event_fragmenter.sv
// Directed bench for turf_event_fragmenter: queued stimulus, handshake monitor, reference model.
// Works with or without TURF_FRAG_HEADER_EN defined.
module tb_turf_event_fragmenter;

`ifdef TURF_FRAG_HEADER_EN
  localparam int unsigned H = 1;
`else
  localparam int unsigned H = 0;
`endif

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [9:0]  nfrag;
  logic [31:0] ip;
  logic [15:0] port;
  logic        open;
  logic        frag_err;

  always #5 clk = ~clk;

  turf_event_fragmenter_if evh ();
  turf_event_fragmenter_if evd ();
  turf_event_fragmenter_if uh ();
  turf_event_fragmenter_if ud ();

  turf_event_fragmenter #(.MAX_FRAG_QWORDS(1024)) dut (
    .aclk              (clk),
    .aresetn           (aresetn),
    .s_evhdr           (evh),
    .s_evdata          (evd),
    .m_udphdr          (uh),
    .m_udpdata         (ud),
    .nfragment_count_i (nfrag),
    .event_ip_i        (ip),
    .event_port_i      (port),
    .event_open_i      (open),
    .frag_err_o        (frag_err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [63:0] hdr_q[$];
  logic [64:0] din_q[$];
  logic [63:0] obs_hdr[$], exp_hdr[$];
  logic [64:0] obs_dat[$], exp_dat[$];

  int unsigned vld_pct = 80;
  int unsigned rdy_pct = 70;
  logic        evh_fire = 1'b0, evd_fire = 1'b0;
  logic        uh_stall = 1'b0, ud_stall = 1'b0;
  logic [63:0] uh_prev = '0, ud_prev = '0;
  int unsigned stall_seen = 0, proto_bad = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pay(input logic [15:0] ev, input int unsigned b);
    return {16'hA5C3, ev, 16'(b), 16'(b) ^ 16'h5A5A};
  endfunction

  // Driver: inputs change 1 time unit after the rising edge.
  initial begin
    evh.tvalid = 1'b0; evh.tdata = '0; evh.tkeep = '1; evh.tlast = 1'b1;
    evd.tvalid = 1'b0; evd.tdata = '0; evd.tkeep = '1; evd.tlast = 1'b0;
    uh.tready = 1'b0;  ud.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!aresetn) begin
        evh.tvalid = 1'b0;
        evd.tvalid = 1'b0;
        uh.tready  = 1'b0;
        ud.tready  = 1'b0;
      end else begin
        if (evh_fire && hdr_q.size() > 0) void'(hdr_q.pop_front());
        evh.tvalid = (hdr_q.size() > 0);
        evh.tdata  = (hdr_q.size() > 0) ? hdr_q[0] : '0;
        if (evd_fire && din_q.size() > 0) void'(din_q.pop_front());
        if (!evd.tvalid || evd_fire)
          evd.tvalid = (din_q.size() > 0) && ($urandom_range(0, 99) < vld_pct);
        if (din_q.size() > 0) begin
          evd.tdata = din_q[0][63:0];
          evd.tlast = din_q[0][64];
        end
        uh.tready = ($urandom_range(0, 99) < rdy_pct);
        ud.tready = ($urandom_range(0, 99) < rdy_pct);
      end
    end
  end

  // Monitor: samples on the falling edge, records handshakes and audits stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        evh_fire = 1'b0; evd_fire = 1'b0;
        uh_stall = 1'b0; ud_stall = 1'b0;
      end else begin
        evh_fire = evh.tvalid && evh.tready;
        evd_fire = evd.tvalid && evd.tready;
        if (uh_stall) begin
          stall_seen++;
          if (!uh.tvalid || uh.tdata !== uh_prev) proto_bad++;
        end
        if (ud_stall) begin
          stall_seen++;
          if (!ud.tvalid || ud.tdata !== ud_prev) proto_bad++;
        end
        uh_stall = uh.tvalid && !uh.tready;
        ud_stall = ud.tvalid && !ud.tready;
        uh_prev  = uh.tdata;
        ud_prev  = ud.tdata;
        if (uh.tvalid && uh.tready) obs_hdr.push_back(uh.tdata);
        if (ud.tvalid && ud.tready) begin
          if (ud.tkeep !== 8'hFF) proto_bad++;
          obs_dat.push_back({ud.tlast, ud.tdata});
        end
      end
    end
  end

  task automatic begin_scn();
    obs_hdr.delete(); obs_dat.delete();
    exp_hdr.delete(); exp_dat.delete();
  endtask

  // Queues one event and appends its expected output using the current configuration.
  task automatic add_event(input int unsigned len, input logic [15:0] ev, input int errbeat);
    int unsigned fs, rem, f, idx, b;
    hdr_q.push_back({32'h0, ev, 16'(len)});
    for (int unsigned i = 0; i < len; i++)
      din_q.push_back({(errbeat >= 0) ? (int'(i) == errbeat) : (i == len - 1), pay(ev, i)});
    if (open && len > 0) begin
      fs = 32'(nfrag) + 1;
      if (fs > 1024) fs = 1024;
      rem = len; idx = 0; b = 0;
      while (rem > 0) begin
        f = (rem < fs) ? rem : fs;
        exp_hdr.push_back({ip, port, 16'(8 * (f + H))});
        if (H == 1) exp_dat.push_back({1'b0, ev, 16'(idx), 15'd0, (f == rem), 16'(f)});
        for (int unsigned k = 0; k < f; k++) begin
          exp_dat.push_back({(k == f - 1), pay(ev, b)});
          b++;
        end
        rem -= f;
        idx++;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    logic done = 1'b0;
    for (int unsigned c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (hdr_q.size() == 0 && din_q.size() == 0 && evh.tready && !uh.tvalid && !ud.tvalid)
        done = 1'b1;
    end
    check({tag, "_done"}, 65'(done), 65'(1));
  endtask

  task automatic wait_dat(input string tag, input int unsigned n);
    logic done = 1'b0;
    for (int unsigned c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (obs_dat.size() >= n) done = 1'b1;
    end
    check({tag, "_reach"}, 65'(done), 65'(1));
  endtask

  task automatic compare(input string tag);
    check({tag, "_nhdr"}, 65'(obs_hdr.size()), 65'(exp_hdr.size()));
    for (int i = 0; i < obs_hdr.size() && i < exp_hdr.size(); i++)
      check($sformatf("%s_hdr%0d", tag, i), {1'b0, obs_hdr[i]}, {1'b0, exp_hdr[i]});
    check({tag, "_ndat"}, 65'(obs_dat.size()), 65'(exp_dat.size()));
    for (int i = 0; i < obs_dat.size() && i < exp_dat.size(); i++)
      check($sformatf("%s_dat%0d", tag, i), obs_dat[i], exp_dat[i]);
  endtask

  logic [15:0] s1_len [3];

  initial begin
    nfrag = 10'd127; ip = 32'h0A000001; port = 16'h1234; open = 1'b1;
    s1_len[0] = (H == 1) ? 16'd1032 : 16'd1024;
    s1_len[1] = (H == 1) ? 16'd1032 : 16'd1024;
    s1_len[2] = (H == 1) ? 16'd360  : 16'd352;

    repeat (3) @(posedge clk);
    #3;
    check("rst_evh_rdy", 65'(evh.tready), 65'(0));
    check("rst_evd_rdy", 65'(evd.tready), 65'(0));
    check("rst_uh_vld",  65'(uh.tvalid), 65'(0));
    check("rst_ud_vld",  65'(ud.tvalid), 65'(0));
    check("rst_err",     65'(frag_err), 65'(0));
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("idle_evh_rdy", 65'(evh.tready), 65'(1));

    // 300 qwords at 128 per fragment; open/nfrag change mid-event must not matter
    begin_scn();
    add_event(300, 16'h0001, -1);
    wait_dat("s1", 1);
    open = 1'b0; nfrag = 10'd3;
    wait_idle("s1");
    compare("s1");
    check("s1_nfrag", 65'(obs_hdr.size()), 65'(3));
    for (int i = 0; i < 3; i++)
      if (i < obs_hdr.size()) check($sformatf("s1_udplen%0d", i), 65'(obs_hdr[i][15:0]), 65'(s1_len[i]));
`ifdef TURF_FRAG_HEADER_EN
    for (int i = 0; i < 3; i++)
      if (129 * i < obs_dat.size()) begin
        check($sformatf("s1_idx%0d", i), 65'(obs_dat[129 * i][47:32]), 65'(i));
        check($sformatf("s1_last%0d", i), 65'(obs_dat[129 * i][16]), 65'(i == 2));
      end
`endif

    // Exact multiple: two fragments, no empty third
    @(posedge clk); #3;
    open = 1'b1; nfrag = 10'd127;
    begin_scn();
    add_event(256, 16'h0002, -1);
    wait_idle("s2");
    compare("s2");
    check("s2_nfrag", 65'(obs_hdr.size()), 65'(2));
`ifdef TURF_FRAG_HEADER_EN
    if (obs_dat.size() > 129) check("s2_lastflag", 65'(obs_dat[129][16]), 65'(1));
`else
    if (obs_dat.size() > 255) check("s2_lasttlast", 65'(obs_dat[255][64]), 65'(1));
`endif

    // Zero-length descriptor
    @(posedge clk); #3;
    begin_scn();
    add_event(0, 16'h0003, -1);
    wait_idle("len0");
    compare("len0");

    // Closed destination: data is drained without output
    @(posedge clk); #3;
    open = 1'b0;
    begin_scn();
    add_event(50, 16'h0004, -1);
    wait_idle("dump");
    compare("dump");
    check("dump_left", 65'(din_q.size()), 65'(0));
    check("dump_err", 65'(frag_err), 65'(0));

    // Ten back-to-back events under heavier backpressure
    @(posedge clk); #3;
    open = 1'b1; nfrag = 10'd12; vld_pct = 60; rdy_pct = 50;
    begin_scn();
    for (int unsigned e = 0; e < 10; e++)
      add_event($urandom_range(1, 70), 16'h0100 + 16'(e), -1);
    wait_idle("multi");
    compare("multi");
    check("multi_err", 65'(frag_err), 65'(0));
    vld_pct = 80; rdy_pct = 70;

    // Early tlast on beat 10 of 20, none on the final beat
    @(posedge clk); #3;
    nfrag = 10'd7;
    begin_scn();
    add_event(20, 16'h0E0E, 9);
    wait_idle("err");
    compare("err");
    check("err_flag", 65'(frag_err), 65'(1));
    @(posedge clk); #3;
    aresetn = 1'b0;
    #1;
    check("err_clr", 65'(frag_err), 65'(0));
    repeat (2) @(posedge clk);
    #3;
    aresetn = 1'b1;

    // Reset in the middle of a payload, then a fresh event
    @(posedge clk); #3;
    nfrag = 10'd3;
    begin_scn();
    add_event(40, 16'h0077, -1);
    wait_dat("rmid", 6);
    @(posedge clk); #3;
    aresetn = 1'b0;
    #1;
    check("rmid_uh_vld",  65'(uh.tvalid), 65'(0));
    check("rmid_ud_vld",  65'(ud.tvalid), 65'(0));
    check("rmid_evd_rdy", 65'(evd.tready), 65'(0));
    check("rmid_evh_rdy", 65'(evh.tready), 65'(0));
    hdr_q.delete(); din_q.delete();
    begin_scn();
    repeat (3) @(posedge clk);
    #3;
    aresetn = 1'b1;
    @(posedge clk); #3;
    add_event(10, 16'h0088, -1);
    wait_idle("post");
    compare("post");
    check("post_nfrag", 65'(obs_hdr.size()), 65'(3));
    if (obs_hdr.size() > 0)
      check("post_udplen0", 65'(obs_hdr[0][15:0]), 65'((H == 1) ? 40 : 32));
`ifdef TURF_FRAG_HEADER_EN
    if (obs_dat.size() > 0) check("post_idx0", 65'(obs_dat[0][47:32]), 65'(0));
`endif

    check("stall_stable", 65'(proto_bad), 65'(0));
    check("stall_seen", 65'(stall_seen != 0), 65'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
